regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between the ALU and load paths into the register file.
// Memory normally wins a conflict; after STARVE_LIMIT consecutive ALU losses the
// ALU gets priority for one grant. Writes to R15 become PC redirects.
// Optional feature macro: WB_CONFLICT_CNT_EN enables the conflict cycle counter;
// when undefined, conflict_cnt is tied to zero.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_stall,
    input  logic        alu_valid,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [3:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pc_we,
    output logic [31:0] pc_wdata,
    output logic [15:0] conflict_cnt
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
    localparam logic [3:0] PcReg     = 4'hF;

    typedef enum logic [0:0] {StMemPri, StAluPri} state_e;

    state_e      state_q;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        alu_xfer, mem_xfer, wb_xfer;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    logic        rf_we_q, pc_we_q;
    logic [3:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q, pc_wdata_q;

    // Grant selection; readies are forced low under reset so a grant in the
    // reset cycle can never be accepted by a requester.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (rst_n && !wb_stall) begin
            if (alu_valid && mem_valid) begin
                if (state_q == StAluPri) begin
                    alu_ready = 1'b1;
                end else begin
                    mem_ready = 1'b1;
                end
            end else begin
                alu_ready = alu_valid;
                mem_ready = mem_valid;
            end
        end
    end

    assign alu_xfer = alu_valid & alu_ready;
    assign mem_xfer = mem_valid & mem_ready;
    assign wb_xfer  = alu_xfer | mem_xfer;
    assign wb_rd    = alu_xfer ? alu_rd : mem_rd;
    assign wb_data  = alu_xfer ? alu_data : mem_data;

    // Next starvation count: cleared by an ALU transfer, bumped by each ALU loss.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (alu_xfer) begin
            starve_cnt_d = '0;
        end else if (alu_valid && !wb_stall && (starve_cnt_q < StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Priority FSM and starvation counter; stalled cycles freeze both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StMemPri;
            starve_cnt_q <= '0;
        end else if (!wb_stall) begin
            starve_cnt_q <= starve_cnt_d;
            unique case (state_q)
                StMemPri: if (starve_cnt_d >= StarveMax) state_q <= StAluPri;
                StAluPri: if (alu_xfer) state_q <= StMemPri;
                default:  state_q <= StMemPri;
            endcase
        end
    end

    // Registered writeback; R15 goes to the PC port and leaves the RF regs alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            pc_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pc_wdata_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            pc_we_q <= 1'b0;
            if (wb_xfer) begin
                if (wb_rd == PcReg) begin
                    pc_we_q    <= 1'b1;
                    pc_wdata_q <= wb_data;
                end else begin
                    rf_we_q    <= 1'b1;
                    rf_waddr_q <= wb_rd;
                    rf_wdata_q <= wb_data;
                end
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign pc_we    = pc_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign pc_wdata = pc_wdata_q;

`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_q;

    // Saturating count of unstalled cycles with both requesters valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
        end else if (alu_valid && mem_valid && !wb_stall && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios then random traffic.
module tb_regfile_wb_arbiter;

    localparam int unsigned LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_stall = 1'b0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_we;
    logic [31:0] pc_wdata;
    logic [15:0] conflict_cnt;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_stall     (wb_stall),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pc_we        (pc_we),
        .pc_wdata     (pc_wdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_pc;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  hold_addr;
        logic [31:0] hold_data;
        logic [31:0] hold_pc;
    } wr_t;

    wr_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who has priority, how many losses the ALU has suffered,
    // and what the architectural write ports should currently hold.
    bit          m_alu_pri;
    int          m_losses;
    int          m_conf;
    logic [3:0]  m_rf_addr;
    logic [31:0] m_rf_data;
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_conflict();
`ifdef WB_CONFLICT_CNT_EN
        return 32'(m_conf);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_alu_pri = 1'b0;
        m_losses  = 0;
        m_conf    = 0;
        m_rf_addr = '0;
        m_rf_data = '0;
        m_pc      = '0;
    endtask

    task automatic push_write(input logic [3:0] rd, input logic [31:0] data);
        wr_t w;
        w.is_pc = (rd == 4'hF);
        w.addr  = rd;
        w.data  = data;
        if (w.is_pc) begin
            m_pc = data;
        end else begin
            m_rf_addr = rd;
            m_rf_data = data;
        end
        w.hold_addr = m_rf_addr;
        w.hold_data = m_rf_data;
        w.hold_pc   = m_pc;
        exp_q.push_back(w);
    endtask

    // One bus cycle: drive at negedge, check grants, advance the model.
    task automatic cycle(input bit av, input logic [3:0] ard, input logic [31:0] ad,
                         input bit mv, input logic [3:0] mrd, input logic [31:0] md,
                         input bit st, output bit ag, output bit mg);
        bit ea, em;
        @(negedge clk);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = md;
        wb_stall  = st;
        #1;
        ea = 1'b0;
        em = 1'b0;
        if (!st) begin
            if (av && mv) begin
                ea = m_alu_pri;
                em = !m_alu_pri;
            end else begin
                ea = av;
                em = mv;
            end
        end
        check("alu_ready", 32'(alu_ready), 32'(ea));
        check("mem_ready", 32'(mem_ready), 32'(em));
        check("conflict_cnt", 32'(conflict_cnt), exp_conflict());
        ag = alu_ready;
        mg = mem_ready;
        if (!st) begin
            if (av && mv && m_conf < 65535) m_conf++;
            if (ea) begin
                push_write(ard, ad);
                m_losses  = 0;
                m_alu_pri = 1'b0;
            end else begin
                if (em) push_write(mrd, md);
                if (av) begin
                    if (m_losses < int'(LIMIT)) m_losses++;
                    if (m_losses == int'(LIMIT)) m_alu_pri = 1'b1;
                end
            end
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expectation.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (rf_we || pc_we) begin
                    check("single_strobe", 32'(rf_we & pc_we), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: rf_we=%0b pc_we=%0b addr=%0d but no transfer",
                                 rf_we, pc_we, rf_waddr);
                    end else begin
                        w = exp_q.pop_front();
                        check("pc_we", 32'(pc_we), 32'(w.is_pc));
                        check("rf_we", 32'(rf_we), 32'(!w.is_pc));
                        if (w.is_pc) begin
                            check("pc_wdata", pc_wdata, w.data);
                            check("rf_waddr_hold", 32'(rf_waddr), 32'(w.hold_addr));
                            check("rf_wdata_hold", rf_wdata, w.hold_data);
                        end else begin
                            check("rf_waddr", 32'(rf_waddr), 32'(w.addr));
                            check("rf_wdata", rf_wdata, w.data);
                            check("pc_wdata_hold", pc_wdata, w.hold_pc);
                        end
                    end
                end else if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_write: got no write, expected rd=%0d data=0x%0h",
                             w.addr, w.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit ag, mg;
        bit [4:0] aseq, mseq;
        bit [7:0] sa, sm;
        bit a_pend, m_pend;
        logic [3:0] a_rd, m_rd;
        logic [31:0] a_d, m_d;

        model_reset();
        // Reset state with both requesters asking: nothing may be granted.
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        #12;
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_pc_we", 32'(pc_we), 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_pc_wdata", pc_wdata, 32'd0);
        check("rst_conflict", 32'(conflict_cnt), 32'd0);
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst_n = 1'b1;

        // Continuous conflict: mem, mem, mem, alu, mem.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'd1, 32'hA0A0_A0A0, 1'b1, 4'd2, 32'h100 + 32'(i), 1'b0, ag, mg);
            aseq[i] = ag;
            mseq[i] = mg;
        end
        check("conflict_alu_seq", 32'(aseq), 32'b01000);
        check("conflict_mem_seq", 32'(mseq), 32'b10111);
        @(posedge clk);
        #2;
`ifdef WB_CONFLICT_CNT_EN
        check("conflict_cnt_5", 32'(conflict_cnt), 32'd5);
`else
        check("conflict_cnt_off", 32'(conflict_cnt), 32'd0);
`endif

        // Lone ALU write.
        cycle(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0, 1'b0, ag, mg);
        check("lone_alu_grant", 32'(ag), 32'd1);
        @(posedge clk);
        #2;
        check("lone_alu_we", 32'(rf_we), 32'd1);
        check("lone_alu_addr", 32'(rf_waddr), 32'd3);
        check("lone_alu_data", rf_wdata, 32'hDEAD_BEEF);

        // R15 redirect from the load path.
        cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h0000_0100, 1'b0, ag, mg);
        @(posedge clk);
        #2;
        check("r15_pc_we", 32'(pc_we), 32'd1);
        check("r15_pc_wdata", pc_wdata, 32'h100);
        check("r15_rf_we", 32'(rf_we), 32'd0);
        check("r15_rf_data_hold", rf_wdata, 32'hDEAD_BEEF);

        // Same destination: load value first, ALU value last.
        cycle(1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0, ag, mg);
        @(posedge clk);
        #2;
        check("same_rd_first", rf_wdata, 32'h22);
        cycle(1'b1, 4'd5, 32'h11, 1'b0, 4'd0, 32'd0, 1'b0, ag, mg);
        @(posedge clk);
        #2;
        check("same_rd_last", rf_wdata, 32'h11);
        check("same_rd_addr", 32'(rf_waddr), 32'd5);

        // Stall keeps the starvation count: mem, mem, stall x4, mem, alu.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'd6, 32'h6666, 1'b1, 4'd7, 32'h7000 + 32'(i),
                  (i >= 2 && i < 6), ag, mg);
            sa[i] = ag;
            sm[i] = mg;
        end
        check("stall_alu_seq", 32'(sa), 32'b1000_0000);
        check("stall_mem_seq", 32'(sm), 32'b0100_0011);

        // Reach ALU priority, then reset in the middle of the ALU grant cycle.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'd8, 32'h8888, 1'b1, 4'd9, 32'h9000 + 32'(i), 1'b0, ag, mg);
        end
        @(negedge clk);
        alu_rd   = 4'd7;
        alu_data = 32'hCAFE_F00D;
        #1;
        check("pre_rst_alu_grant", 32'(alu_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_alu_ready", 32'(alu_ready), 32'd0);
        check("midrst_mem_ready", 32'(mem_ready), 32'd0);
        check("midrst_rf_we", 32'(rf_we), 32'd0);
        check("midrst_pc_we", 32'(pc_we), 32'd0);
        check("midrst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("midrst_rf_wdata", rf_wdata, 32'd0);
        check("midrst_pc_wdata", pc_wdata, 32'd0);
        check("midrst_conflict", 32'(conflict_cnt), 32'd0);
        @(posedge clk);
        #2;
        check("midrst_no_write", 32'(rf_we | pc_we), 32'd0);
        @(negedge clk);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst_n = 1'b1;
        cycle(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 1'b0, ag, mg);
        check("post_rst_mem_pri", 32'({ag, mg}), 32'b01);
        @(posedge clk);
        #2;
        check("post_rst_write", rf_wdata, 32'h2);

        // Random traffic; each requester holds its payload until accepted.
        a_pend = 1'b1;
        a_rd   = 4'd1;
        a_d    = 32'h1;
        m_pend = 1'b0;
        m_rd   = '0;
        m_d    = '0;
        for (int n = 0; n < 800; n++) begin
            if (!a_pend && $urandom_range(0, 99) < 60) begin
                a_pend = 1'b1;
                a_rd   = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                a_d    = $urandom;
            end
            if (!m_pend && $urandom_range(0, 99) < 60) begin
                m_pend = 1'b1;
                m_rd   = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                m_d    = $urandom;
            end
            cycle(a_pend, a_rd, a_d, m_pend, m_rd, m_d, ($urandom_range(0, 9) == 0), ag, mg);
            if (ag) a_pend = 1'b0;
            if (mg) m_pend = 1'b0;
        end

        cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, ag, mg);
        cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, ag, mg);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
